spi_master_nbit: RTL and testbench
==================================

# spi_master_nbit

Parametrised SPI master (mode 0: CPOL=0, CPHA=0) with a configurable packet width up to `NBITS`, `NCS` active-low chip selects and a programmable SCLK half-period. It replaces the fixed single-CS SPI master controller and its mosi/miso shift-register pair, and sits between a val/rdy message interface on the core side and the external SPI pins. Packet size and chip-select address are runtime configuration registers, each written through its own val/rdy port.

## Interface
Parameters:
- `NBITS`, default 32: maximum packet width in bits; width of `recv_msg`/`send_msg`.
- `NCS`, default 2: number of chip-select lines.
- `HALF_PERIOD`, default 1: `clk` cycles per SCLK phase (≥1).
- Derived, not overridable: `PW = $clog2(NBITS)+1`, `AW = max(1,$clog2(NCS))`.

Ports:
- Clocking: one clock, `clk`; reset is synchronous and active-high, `reset`.
- `clk  in  1`: clock.
- `reset  in  1`: synchronous active-high reset.
- `recv_val  in  1`, `recv_rdy  out  1`, `recv_msg  in  NBITS`: transmit data request.
- `send_val  out  1`, `send_rdy  in  1`, `send_msg  out  NBITS`: received data response.
- `packet_size_val  in  1`, `packet_size_rdy  out  1`, `packet_size_msg  in  PW`: packet length n.
- `cs_addr_val  in  1`, `cs_addr_rdy  out  1`, `cs_addr_msg  in  AW`: chip-select index.
- `cs  out  NCS`: active-low chip selects.
- `sclk  out  1`, `mosi  out  1`: SPI clock and serial data out.
- `miso  in  1`: SPI serial data in.

## Operation
- **States:** IDLE, CS_SETUP, SCLK_HIGH, SCLK_LOW, DONE.
- **IDLE:**
  - `recv_rdy`, `packet_size_rdy` and `cs_addr_rdy` are all 1.
  - On a recv handshake: latch `recv_msg`, the current size register n and the current CS register, clear the receive shift register, then go to CS_SETUP.
- **Config registers:**
  - Written on their handshake; only writable in IDLE.
  - `packet_size_msg` of 0 or >NBITS stores NBITS.
  - `cs_addr_msg` ≥NCS is accepted but dropped; the register keeps its old value.
  - A config write in the same cycle as a recv handshake does not affect that transaction.
- **CS_SETUP** (HALF_PERIOD cycles): `cs[addr]`=0, `sclk`=0, `mosi`=bit n-1 of the latched data.
- **SCLK_HIGH** (HALF_PERIOD cycles):
  - `sclk`=1.
  - `miso` is sampled at the clk edge ending the first cycle of the phase and shifted into the receive register at the LSB.
- **SCLK_LOW** (HALF_PERIOD cycles):
  - `sclk`=0; `mosi` advances to the next lower bit on entry.
  - After the nth SCLK_LOW go to DONE; otherwise go to SCLK_HIGH. The last SCLK_LOW is the CS hold time.
- **Bit order:** transmit is MSB first over bits [n-1:0] of `recv_msg`. `send_msg[n-1:0]` holds the received bits, first-received at bit n-1; `send_msg[NBITS-1:n]`=0.
- **DONE:**
  - All `cs`=1, `send_val`=1, all rdy outputs 0.
  - On a send handshake, go to IDLE.
- **Reset values:**
  - While `reset` is high: `recv_rdy`=0, `send_val`=0, both config rdys 0, `cs`=all ones, `sclk`=0, `mosi`=0, `send_msg`=0.
  - Size register resets to NBITS; CS register resets to 0.
  - First cycle after reset: IDLE.
- **Reset mid-transaction:** abort at the next edge. `cs` deasserts and no `send_val` is produced.

## Timing
- Let H=HALF_PERIOD and the recv handshake occur in cycle T.
- `cs[addr]` is low in cycles T+1 … T+H(2n+1). `recv_rdy` is 0 over the same span.
- SCLK rising edges occur at cycles T+1+H(2k+1), k=0…n-1.
- `send_val` rises in cycle T+H(2n+1)+1 and holds with `send_msg` stable until `send_rdy`.
- `send_val`&`send_rdy` in cycle D gives `recv_rdy`=1 in D+1. Back-to-back throughput is one packet per H(2n+1)+2 cycles with `send_rdy` tied high.
- Unselected `cs` lines stay 1 throughout. `sclk` idles at 0 and never glitches.

## Test plan
- **Reset defaults:** reset, then one 32-bit transfer of 0xA5A5_0F0F with `miso` looped to `mosi` -> `send_msg`=0xA5A5_0F0F; `cs[0]` low for 65 cycles.
- **Short packet:**
  - Stimulus: size=8, cs_addr=1, `recv_msg`=0xFFFF_FF3C, `miso` driven 0x96 MSB first.
  - Required response: `mosi` carries 0x3C; `cs[1]` low 17 cycles while `cs[0]` stays 1; `send_msg`=0x0000_0096.
- **Half-period:** H=3, size=4, data 0x9 -> each `sclk` phase lasts 3 cycles; `send_val` rises 28 cycles after the handshake.
- **Config edge cases:**
  - size=0 -> 32-bit transfer.
  - cs_addr=3 with NCS=2 -> CS stays 1.
  - Size write in the same cycle as a recv handshake -> that packet uses the old size.
- **Backpressure:** `send_rdy` held low 10 cycles -> `send_val` and `send_msg` stable; `recv_rdy`=0 until acceptance; `recv_rdy`=1 the cycle after.
- **Mid-transfer reset:** reset asserted at bit 5 -> next cycle all `cs`=1, `sclk`=0, `send_val`=0; a subsequent transfer completes correctly.

Source files
------------

// File: rtl/spi_master_nbit.sv
// SPI mode-0 master with runtime packet length (1..NBITS), NCS active-low chip selects
// and a programmable SCLK half-period; val/rdy on the core side.
module spi_master_nbit #(
  parameter int unsigned NBITS       = 32,
  parameter int unsigned NCS         = 2,
  parameter int unsigned HALF_PERIOD = 1,
  localparam int unsigned PW         = $clog2(NBITS) + 1,
  localparam int unsigned AW         = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [NBITS-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [NBITS-1:0] send_msg,
  input  logic             packet_size_val,
  output logic             packet_size_rdy,
  input  logic [PW-1:0]    packet_size_msg,
  input  logic             cs_addr_val,
  output logic             cs_addr_rdy,
  input  logic [AW-1:0]    cs_addr_msg,
  output logic [NCS-1:0]   cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StSclkHigh,
    StSclkLow,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    bit_q;
  logic [PW-1:0]    n_q;
  logic [PW-1:0]    size_q;
  logic [AW-1:0]    cs_reg_q;
  logic [AW-1:0]    sel_q;
  logic [NBITS-1:0] tx_q;
  logic [NBITS-1:0] rx_q;
  logic             sclk_q;
  logic [NCS-1:0]   cs_q, cs_d;
  logic             phase_end;
  logic             active_q, active_d;
  logic             idle;
  logic [AW-1:0]    sel_next;

  assign idle      = (state_q == StIdle);
  assign phase_end = (cnt_q == CW'(HALF_PERIOD - 1));
  assign active_q  = (state_q == StCsSetup) || (state_q == StSclkHigh) || (state_q == StSclkLow);
  assign active_d  = (state_d == StCsSetup) || (state_d == StSclkHigh) || (state_d == StSclkLow);
  // The CS register is latched on the handshake, so the entry cycle must look at it directly.
  assign sel_next  = idle ? cs_reg_q : sel_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (recv_val) state_d = StCsSetup;
      StCsSetup:  if (phase_end) state_d = StSclkHigh;
      StSclkHigh: if (phase_end) state_d = StSclkLow;
      StSclkLow:  if (phase_end) state_d = (bit_q == n_q - PW'(1)) ? StDone : StSclkHigh;
      StDone:     if (send_rdy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    cs_d = '1;
    for (int i = 0; i < NCS; i++) begin
      if (active_d && (i == int'(sel_next))) cs_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      n_q      <= '0;
      size_q   <= PW'(NBITS);
      cs_reg_q <= '0;
      sel_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= '1;
    end else begin
      state_q <= state_d;
      sclk_q  <= (state_d == StSclkHigh);
      cs_q    <= cs_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
      if (idle && recv_val) begin
        // Left-align the n-bit payload so mosi is always the MSB of tx_q.
        tx_q  <= recv_msg << (PW'(NBITS) - size_q);
        rx_q  <= '0;
        n_q   <= size_q;
        sel_q <= cs_reg_q;
        bit_q <= '0;
      end
      if (state_q == StSclkHigh && cnt_q == '0) rx_q <= {rx_q[NBITS-2:0], miso};
      if (state_q == StSclkHigh && phase_end) tx_q <= tx_q << 1;
      if (state_q == StSclkLow && phase_end) bit_q <= bit_q + PW'(1);
      if (idle && packet_size_val) begin
        size_q <= (packet_size_msg == '0 || packet_size_msg > PW'(NBITS)) ?
                  PW'(NBITS) : packet_size_msg;
      end
      if (idle && cs_addr_val && (int'(cs_addr_msg) < int'(NCS))) cs_reg_q <= cs_addr_msg;
    end
  end

  always_comb begin
    recv_rdy        = idle && !reset;
    packet_size_rdy = idle && !reset;
    cs_addr_rdy     = idle && !reset;
    send_val        = (state_q == StDone) && !reset;
    send_msg        = reset ? '0 : rx_q;
    cs              = reset ? '1 : cs_q;
    sclk            = sclk_q && !reset;
    mosi            = active_q && !reset && tx_q[NBITS-1];
  end

endmodule

// File: tb/tb_spi_master_nbit.sv
// Directed bench: table of transfers on an H=1 instance plus corner-case sequences,
// and a half-period / CS-drop check on an H=3, NCS=3 instance.
module tb_spi_master_nbit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        recv_val = 1'b0, recv_rdy;
  logic [31:0] recv_msg = '0;
  logic        send_val, send_rdy = 1'b0;
  logic [31:0] send_msg;
  logic        ps_val = 1'b0, ps_rdy;
  logic [5:0]  ps_msg = '0;
  logic        ca_val = 1'b0, ca_rdy;
  logic [0:0]  ca_msg = '0;
  logic [1:0]  cs;
  logic        sclk, mosi, miso = 1'b0;

  logic        r3_val = 1'b0, r3_rdy;
  logic [31:0] r3_msg = '0;
  logic        s3_val;
  logic [31:0] s3_msg;
  logic        p3_val = 1'b0, p3_rdy;
  logic [5:0]  p3_msg = '0;
  logic        c3_val = 1'b0, c3_rdy;
  logic [1:0]  c3_msg = '0;
  logic [2:0]  cs3;
  logic        sclk3, mosi3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_master_nbit #(.NBITS(32), .NCS(2), .HALF_PERIOD(1)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
    .packet_size_val(ps_val), .packet_size_rdy(ps_rdy), .packet_size_msg(ps_msg),
    .cs_addr_val(ca_val), .cs_addr_rdy(ca_rdy), .cs_addr_msg(ca_msg),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_master_nbit #(.NBITS(32), .NCS(3), .HALF_PERIOD(3)) dut3 (
    .clk(clk), .reset(reset),
    .recv_val(r3_val), .recv_rdy(r3_rdy), .recv_msg(r3_msg),
    .send_val(s3_val), .send_rdy(1'b1), .send_msg(s3_msg),
    .packet_size_val(p3_val), .packet_size_rdy(p3_rdy), .packet_size_msg(p3_msg),
    .cs_addr_val(c3_val), .cs_addr_rdy(c3_rdy), .cs_addr_msg(c3_msg),
    .cs(cs3), .sclk(sclk3), .mosi(mosi3), .miso(1'b0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int size_v, input int cs_v);
    @(negedge clk);
    if (size_v >= 0) begin ps_val = 1'b1; ps_msg = 6'(size_v); end
    if (cs_v >= 0) begin ca_val = 1'b1; ca_msg = 1'(cs_v); end
    @(posedge clk);
    @(negedge clk);
    ps_val = 1'b0;
    ca_val = 1'b0;
  endtask

  // One transfer on dut; cycle count c is relative to the handshake cycle T.
  task automatic run_xfer(input logic [31:0] data, input logic [31:0] pat, input bit loop,
                          input int n, input int same_size, input int ack_delay,
                          output logic [31:0] got, output logic [31:0] mosi_bits,
                          output int c0, output int c1, output int sv_at,
                          output bit hold_ok, output bit rdy_after);
    int c, k;
    logic prev;
    @(negedge clk);
    recv_val = 1'b1;
    recv_msg = data;
    if (same_size >= 0) begin ps_val = 1'b1; ps_msg = 6'(same_size); end
    @(posedge clk);
    @(negedge clk);
    recv_val = 1'b0;
    ps_val = 1'b0;
    c = 1; k = 0; prev = 1'b0; c0 = 0; c1 = 0; sv_at = -1; mosi_bits = '0;
    while (c < 300 && sv_at < 0) begin
      if (!cs[0]) c0++;
      if (!cs[1]) c1++;
      if (sclk && !prev) begin
        mosi_bits = {mosi_bits[30:0], mosi};
        miso = loop ? mosi : ((k < n) ? pat[n-1-k] : 1'b0);
        k++;
      end
      prev = sclk;
      if (send_val) sv_at = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    got = send_msg;
    hold_ok = 1'b1;
    repeat (ack_delay) begin
      @(negedge clk);
      if (!send_val || send_msg !== got || recv_rdy) hold_ok = 1'b0;
    end
    send_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send_rdy = 1'b0;
    rdy_after = recv_rdy;
  endtask

  typedef struct {
    int          size_wr;
    int          cs_wr;
    logic [31:0] data;
    logic [31:0] pat;
    bit          loop;
    int          n;
    logic [31:0] exp_msg;
    logic [31:0] exp_mosi;
    int          exp_c0;
    int          exp_c1;
    int          exp_sv;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] got, mb;
    int c0, c1, sv, c, rises, hi_cycles, first_rise;
    bit hold_ok, rdy_after;
    logic prev;

    vecs[0] = '{-1, -1, 32'hA5A5_0F0F, 32'h0, 1'b1, 32, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 65, 0, 66};
    vecs[1] = '{8, 1, 32'hFFFF_FF3C, 32'h96, 1'b0, 8, 32'h0000_0096, 32'h3C, 0, 17, 18};
    vecs[2] = '{0, 0, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 32, 32'hCAFE_F00D, 32'h1234_5678,
                65, 0, 66};
    vecs[3] = '{4, -1, 32'h0000_000B, 32'h5, 1'b0, 4, 32'h5, 32'hB, 9, 0, 10};
    vecs[4] = '{16, 1, 32'h0000_BEEF, 32'h0, 1'b1, 16, 32'h0000_BEEF, 32'hBEEF, 0, 33, 34};

    // Reset state, observed while reset is still high.
    repeat (3) @(negedge clk);
    check("rst_recv_rdy", 32'(recv_rdy), 32'd0);
    check("rst_send_val", 32'(send_val), 32'd0);
    check("rst_cfg_rdy", 32'({ps_rdy, ca_rdy}), 32'd0);
    check("rst_cs", 32'(cs), 32'h3);
    check("rst_sclk_mosi", 32'({sclk, mosi}), 32'd0);
    check("rst_send_msg", send_msg, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_recv_rdy", 32'(recv_rdy), 32'd1);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].size_wr >= 0 || vecs[i].cs_wr >= 0) cfg_write(vecs[i].size_wr, vecs[i].cs_wr);
      run_xfer(vecs[i].data, vecs[i].pat, vecs[i].loop, vecs[i].n, -1, 0,
               got, mb, c0, c1, sv, hold_ok, rdy_after);
      check($sformatf("v%0d_msg", i), got, vecs[i].exp_msg);
      check($sformatf("v%0d_mosi", i), mb, vecs[i].exp_mosi);
      check($sformatf("v%0d_cs0_low", i), 32'(c0), 32'(vecs[i].exp_c0));
      check($sformatf("v%0d_cs1_low", i), 32'(c1), 32'(vecs[i].exp_c1));
      check($sformatf("v%0d_send_val_at", i), 32'(sv), 32'(vecs[i].exp_sv));
      check($sformatf("v%0d_rdy_after", i), 32'(rdy_after), 32'd1);
    end

    // Size write alongside the recv handshake: that packet keeps 16 bits, the next uses 8.
    run_xfer(32'h0000_A5C3, 32'h0, 1'b1, 16, 8, 0, got, mb, c0, c1, sv, hold_ok, rdy_after);
    check("same_cyc_msg", got, 32'h0000_A5C3);
    check("same_cyc_cs1_low", 32'(c1), 32'd33);
    run_xfer(32'h0000_005A, 32'h0, 1'b1, 8, -1, 0, got, mb, c0, c1, sv, hold_ok, rdy_after);
    check("after_same_msg", got, 32'h0000_005A);
    check("after_same_cs1_low", 32'(c1), 32'd17);

    // Backpressure: send_rdy held low for 10 cycles.
    run_xfer(32'h0000_0081, 32'h42, 1'b0, 8, -1, 10, got, mb, c0, c1, sv, hold_ok, rdy_after);
    check("bp_msg", got, 32'h0000_0042);
    check("bp_hold_stable", 32'(hold_ok), 32'd1);
    check("bp_rdy_after", 32'(rdy_after), 32'd1);

    // Half-period 3 on dut3, with an out-of-range CS write that must be dropped.
    @(negedge clk);
    p3_val = 1'b1; p3_msg = 6'd4; c3_val = 1'b1; c3_msg = 2'd3;
    @(posedge clk);
    @(negedge clk);
    p3_val = 1'b0; c3_val = 1'b0;
    r3_val = 1'b1; r3_msg = 32'h9;
    @(posedge clk);
    @(negedge clk);
    r3_val = 1'b0;
    c = 1; rises = 0; hi_cycles = 0; first_rise = -1; c0 = 0; c1 = 0; sv = -1; prev = 1'b0;
    mb = '0;
    while (c < 200 && sv < 0) begin
      if (!cs3[0]) c0++;
      if (!cs3[1] || !cs3[2]) c1++;
      if (sclk3) hi_cycles++;
      if (sclk3 && !prev) begin
        rises++;
        mb = {mb[30:0], mosi3};
        if (first_rise < 0) first_rise = c;
      end
      prev = sclk3;
      if (s3_val) sv = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    check("h3_send_val_at", 32'(sv), 32'd28);
    check("h3_first_rise", 32'(first_rise), 32'd4);
    check("h3_rises", 32'(rises), 32'd4);
    check("h3_high_cycles", 32'(hi_cycles), 32'd12);
    check("h3_mosi", mb, 32'h9);
    check("h3_cs0_low", 32'(c0), 32'd27);
    check("h3_other_cs_low", 32'(c1), 32'd0);
    check("h3_msg", s3_msg, 32'h0);

    // Reset at bit 5 of a transfer.
    @(negedge clk);
    recv_val = 1'b1; recv_msg = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    recv_val = 1'b0;
    rises = 0; prev = 1'b0; c = 0;
    while (rises < 5 && c < 100) begin
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises < 5) begin
        @(negedge clk);
        c++;
      end
    end
    check("mid_reached_bit5", 32'(rises), 32'd5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_cs", 32'(cs), 32'h3);
    check("mid_rst_sclk_sv", 32'({sclk, send_val}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_post_cs", 32'(cs), 32'h3);
    check("mid_post_sclk_sv", 32'({sclk, send_val}), 32'd0);
    check("mid_post_recv_rdy", 32'(recv_rdy), 32'd1);
    run_xfer(32'h0F1E_2D3C, 32'h0, 1'b1, 32, -1, 0, got, mb, c0, c1, sv, hold_ok, rdy_after);
    check("mid_after_msg", got, 32'h0F1E_2D3C);
    check("mid_after_cs0_low", 32'(c0), 32'd65);
    check("mid_after_send_val_at", 32'(sv), 32'd66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
